// File: rtl/rf_write_sched_pkg.sv
// Shared constants and the write-request bus type used by the write-port scheduler.
// Pure declarations; no logic, no latency.
// Not applicable; carries no flow control of its own.
package rf_write_sched_pkg;

  localparam int RF_NUM_REGS  = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_DATA_W    = 32;
  localparam int RF_BUF_DEPTH = 2;

  // One register-file write request: used for the WB, long-unit and RF buses.
  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] rd;
    logic [RF_DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_write_sched_fifo.sv
// Small holding FIFO for long-unit results that lost write-port arbitration.
// Push visible at head the cycle after the edge; pop takes effect at the edge.
// Push ignored when full, pop ignored when empty; caller gates with full/empty.
module rf_wr_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers and occupancy; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it carries no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rf_write_sched.sv
// Merges WB writebacks and long-unit results onto the single RF write port; scoreboards long-unit rd.
// Write path is combinational (0 cycles); busy_map updates at the next edge.
// WB always wins; long-unit results buffer in the FIFO, lu_ready drops when it is full.
module rf_write_sched
  import rf_write_sched_pkg::*;
#(
  parameter int NUM_REGS  = RF_NUM_REGS,
  parameter int ADDR_W    = RF_ADDR_W,
  parameter int DATA_W    = RF_DATA_W,
  parameter int BUF_DEPTH = RF_BUF_DEPTH
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [ADDR_W-1:0]   id_rs1,
  input  logic [ADDR_W-1:0]   id_rs2,
  input  logic [ADDR_W-1:0]   id_rd,
  input  logic                id_rd_we,
  input  logic                id_issue_long,
  output logic                stall_id,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                lu_valid,
  input  logic [ADDR_W-1:0]   lu_rd,
  input  logic [DATA_W-1:0]   lu_data,
  output logic                lu_ready,
  output logic                rf_regwrite,
  output logic [ADDR_W-1:0]   rf_write_reg,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] busy_map
);

  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int ENT_W  = ADDR_W + DATA_W;

  wr_req_t              wb_req, lu_req, head_req, rf_req;
  logic [ENT_W-1:0]     head_dat;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 fifo_push, fifo_pop, bypass;
  logic                 issue, lu_clr;
  logic [NUM_REGS-1:0]  busy_q, busy_d;

  assign wb_req   = '{valid: wb_valid, rd: wb_rd, data: wb_data};
  assign lu_req   = '{valid: lu_valid, rd: lu_rd, data: lu_data};
  assign head_req = '{valid: ~fifo_empty, rd: head_dat[ENT_W-1:DATA_W], data: head_dat[DATA_W-1:0]};

  // Acceptance depends on stored occupancy only, so a full FIFO never pops-through.
  assign lu_ready  = (fifo_count < CNT_W'(BUF_DEPTH));
  assign fifo_push = lu_valid & ~fifo_full & ~bypass;

  rf_wr_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (fifo_push),
    .data_i  ({lu_rd, lu_data}),
    .pop_i   (fifo_pop),
    .data_o  (head_dat),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Write-port arbitration: WB, then oldest buffered result, then direct long-unit bypass.
  always_comb begin
    rf_req   = '0;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (wb_req.valid) begin
      rf_req = wb_req;
    end else if (head_req.valid) begin
      rf_req   = head_req;
      fifo_pop = 1'b1;
    end else if (lu_req.valid) begin
      rf_req = lu_req;
      bypass = 1'b1;
    end
  end

  // x0 writes are consumed but never reach the register file.
  assign rf_regwrite   = rf_req.valid & (rf_req.rd != '0);
  assign rf_write_reg  = rf_req.rd;
  assign rf_write_data = rf_req.data;

  assign stall_id = id_valid & (busy_q[id_rs1] | busy_q[id_rs2] | (id_rd_we & busy_q[id_rd]));
  assign issue    = id_valid & id_issue_long & id_rd_we & ~stall_id & (id_rd != '0);
  assign lu_clr   = fifo_pop | bypass;

  // Scoreboard next state: long-unit writes clear, issues set; set is applied last so it wins.
  always_comb begin
    busy_d = busy_q;
    if (lu_clr) busy_d[rf_req.rd] = 1'b0;
    if (issue)  busy_d[id_rd]     = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Pending-write bitmap register; reset forgets all outstanding long-unit writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_map = busy_q;

endmodule

// File: tb/tb_rf_write_sched.sv
module tb_rf_write_sched;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int DEPTH = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          id_valid, id_rd_we, id_issue_long;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          stall_id;
  logic          wb_valid;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          lu_valid;
  logic [AW-1:0] lu_rd;
  logic [DW-1:0] lu_data;
  logic          lu_ready;
  logic          rf_regwrite;
  logic [AW-1:0] rf_write_reg;
  logic [DW-1:0] rf_write_data;
  logic [NR-1:0] busy_map;

  rf_write_sched dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_issue_long(id_issue_long), .stall_id(stall_id),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_regwrite(rf_regwrite), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .busy_map(busy_map)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  // Reference model: queue of held long-unit results and a pending bit per register.
  ent_t          q[$];
  logic [NR-1:0] busy;
  logic          lu_taken;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_we = 0; id_issue_long = 0;
    wb_valid = 0; wb_rd = 0; wb_data = 0;
    lu_valid = 0; lu_rd = 0; lu_data = 0;
  endtask

  task automatic set_id(input logic v, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] rd, input logic we, input logic lng);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rd_we = we; id_issue_long = lng;
  endtask

  // Compare every output against the model, then advance one clock with the model.
  task automatic tick();
    logic          e_rdy, e_stall, e_we, e_issue;
    logic [AW-1:0] e_rd;
    logic [DW-1:0] e_data;
    int            src;
    #1;
    e_rdy   = (q.size() < DEPTH);
    e_stall = id_valid && (busy[id_rs1] || busy[id_rs2] || (id_rd_we && busy[id_rd]));
    src = 0; e_rd = 0; e_data = 0;
    if (wb_valid)          begin src = 1; e_rd = wb_rd;    e_data = wb_data;    end
    else if (q.size() > 0) begin src = 2; e_rd = q[0].rd;  e_data = q[0].data;  end
    else if (lu_valid)     begin src = 3; e_rd = lu_rd;    e_data = lu_data;    end
    e_we    = (src != 0) && (e_rd != 0);
    e_issue = id_valid && id_issue_long && id_rd_we && !e_stall && (id_rd != 0);

    chk("stall_id", stall_id, e_stall);
    chk("lu_ready", lu_ready, e_rdy);
    chk("busy_map", busy_map, busy);
    chk("rf_regwrite", rf_regwrite, e_we);
    if (e_we) begin
      chk("rf_write_reg", rf_write_reg, e_rd);
      chk("rf_write_data", rf_write_data, e_data);
    end

    lu_taken = lu_valid && (src == 3 || e_rdy);
    if (src == 2) begin busy[q[0].rd] = 1'b0; void'(q.pop_front()); end
    if (src == 3) busy[lu_rd] = 1'b0;
    if (lu_valid && e_rdy && src != 3) q.push_back('{rd: lu_rd, data: lu_data});
    if (e_issue) busy[id_rd] = 1'b1;
    busy[0] = 1'b0;

    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    idle();
    reset = 0;
    q.delete();
    busy = '0;
    lu_taken = 0;
    set_id(1, 3, 4, 5, 1, 0);
    #2;
    chk("rst_busy_map", busy_map, 0);
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_stall", stall_id, 0);
    chk("rst_regwrite", rf_regwrite, 0);
    @(negedge clock);
    reset = 1;
    idle();
    tick();

    // WB only, including an x0 writeback.
    wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    #1;
    chk("wb_we", rf_regwrite, 1);
    chk("wb_reg", rf_write_reg, 5);
    chk("wb_data", rf_write_data, 32'hDEADBEEF);
    tick();
    wb_rd = 0;
    #1;
    chk("wb_x0_we", rf_regwrite, 0);
    tick();
    idle();

    // Bypass of x7 after issuing a long op to x7.
    set_id(1, 0, 0, 7, 1, 1);
    tick();
    idle();
    lu_valid = 1; lu_rd = 7; lu_data = 32'h11;
    #1;
    chk("byp_we", rf_regwrite, 1);
    chk("byp_reg", rf_write_reg, 7);
    chk("byp_busy7_before", busy_map[7], 1);
    tick();
    idle();
    #1;
    chk("byp_busy7_after", busy_map[7], 0);
    chk("byp_ready", lu_ready, 1);
    tick();

    // Contention: WB holds the port for 4 cycles while x8, x9, x10 arrive.
    wb_valid = 1; wb_rd = 20; wb_data = 32'hAAAA;
    lu_valid = 1; lu_rd = 8; lu_data = 32'h1;
    tick();
    lu_rd = 9; lu_data = 32'h2;
    tick();
    lu_rd = 10; lu_data = 32'h3;
    #1;
    chk("cont_full_ready", lu_ready, 0);
    tick();
    tick();
    wb_valid = 0;
    #1;
    chk("cont_w0_reg", rf_write_reg, 8);
    chk("cont_w0_data", rf_write_data, 1);
    chk("cont_still_full", lu_ready, 0);
    tick();
    #1;
    chk("cont_w1_reg", rf_write_reg, 9);
    chk("cont_ready_again", lu_ready, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("cont_w2_reg", rf_write_reg, 10);
    chk("cont_w2_data", rf_write_data, 3);
    tick();
    idle();
    tick();

    // RAW stall on x3 released the cycle after the long-unit write.
    set_id(1, 0, 0, 3, 1, 1);
    tick();
    set_id(1, 3, 0, 1, 1, 0);
    #1;
    chk("raw_stall0", stall_id, 1);
    tick();
    lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
    #1;
    chk("raw_stall_wrcyc", stall_id, 1);
    tick();
    lu_valid = 0;
    #1;
    chk("raw_release", stall_id, 0);
    tick();

    // Unrelated ID, WAW stall, x0 long issue.
    set_id(1, 0, 0, 3, 1, 1);
    tick();
    set_id(1, 4, 6, 2, 1, 0);
    #1;
    chk("unrel_stall", stall_id, 0);
    tick();
    set_id(1, 0, 0, 3, 1, 0);
    #1;
    chk("waw_stall", stall_id, 1);
    tick();
    set_id(1, 0, 0, 0, 1, 1);
    tick();
    idle();
    #1;
    chk("x0_issue_map", busy_map, 32'h0000_0008);
    tick();
    lu_valid = 1; lu_rd = 3; lu_data = 32'h3;
    tick();
    idle();
    tick();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = AW'($urandom_range(0, 7));
      id_rs2        = AW'($urandom_range(0, 7));
      id_rd         = AW'($urandom_range(0, 7));
      id_rd_we      = ($urandom_range(0, 3) != 0);
      id_issue_long = ($urandom_range(0, 2) == 0);
      wb_valid      = ($urandom_range(0, 4) < 2);
      wb_rd         = AW'($urandom_range(0, 7));
      wb_data       = $urandom;
      if (!(lu_valid && !lu_taken)) begin
        lu_valid = ($urandom_range(0, 1) == 1);
        lu_rd    = AW'($urandom_range(0, 7));
        lu_data  = $urandom;
      end
      tick();
    end
    idle();
    lu_taken = 0;
    tick();
    tick();
    tick();

    // Reset mid-burst with two buffered entries and a pending bit.
    wb_valid = 1; wb_rd = 20; wb_data = 32'h5;
    lu_valid = 1; lu_rd = 11; lu_data = 32'hB;
    set_id(1, 0, 0, 12, 1, 1);
    tick();
    id_valid = 0;
    lu_rd = 12; lu_data = 32'hC;
    tick();
    idle();
    reset = 0;
    q.delete();
    busy = '0;
    #1;
    chk("mid_rst_busy", busy_map, 0);
    chk("mid_rst_ready", lu_ready, 1);
    chk("mid_rst_we", rf_regwrite, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1;
    for (int i = 0; i < 4; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
Write-port scheduler and scoreboard for the ID-stage register file, which has one write port. It merges in-order WB-stage writebacks with out-of-order results from a long-latency unit (mul/div) onto the single write port. It tracks registers with outstanding long-latency writes and stalls ID on RAW/WAW hazards against them. It sits between the EX/WB stages and the register file's regwrite/write_reg/write_data inputs.

Parameters:
NUM_REGS, 32, architectural register count
ADDR_W, 5, register index width
DATA_W, 32, register data width
BUF_DEPTH, 2, long-unit result holding FIFO depth (power of two, >=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
id_valid  input  1  valid instruction in ID
id_rs1  input  ADDR_W  ID source register 1
id_rs2  input  ADDR_W  ID source register 2
id_rd  input  ADDR_W  ID destination register
id_rd_we  input  1  ID instruction writes rd
id_issue_long  input  1  ID instruction goes to long-latency unit
stall_id  output  1  hold ID/IF this cycle
wb_valid  input  1  WB-stage write request (always accepted)
wb_rd  input  ADDR_W  WB destination
wb_data  input  DATA_W  WB data
lu_valid  input  1  long-unit result valid
lu_rd  input  ADDR_W  long-unit destination
lu_data  input  DATA_W  long-unit data
lu_ready  output  1  scheduler accepts long-unit result
rf_regwrite  output  1  to register file regwrite
rf_write_reg  output  ADDR_W  to register file write_reg
rf_write_data  output  DATA_W  to register file write_data
busy_map  output  NUM_REGS  registered pending-write bitmap

Behaviour:
- Reset (reset=0, asynchronous): busy_map=0, FIFO empty (count=0, pointers 0), lu_ready=1. Combinational outputs follow from this state: stall_id=0; rf_regwrite=0 unless wb_valid.
- Reset mid-operation discards buffered results and clears all pending bits.
- Write-port priority, evaluated each cycle (combinational, 0-cycle latency):
  1. wb_valid=1: drive WB request.
  2. Else FIFO non-empty: pop the head and drive it.
  3. Else lu_valid=1: bypass the long-unit result directly. It is not stored in the FIFO.
  4. Else rf_regwrite=0.
- Writes to x0 never assert rf_regwrite. They are still consumed (popped/accepted).
- Register file latches on the clock edge, so a value written in cycle N is readable in ID in cycle N+1.
- Accept rule:
  - lu_ready = (count < BUF_DEPTH). It depends on registered count only; there is no pop-through when full.
  - On lu_valid & lu_ready, the result goes to the FIFO tail, unless the bypass path (rule 3) consumes it.
  - Simultaneous push and pop: count unchanged, pointers wrap modulo BUF_DEPTH.
- Producer contract: lu_rd/lu_data are held while lu_valid & ~lu_ready.
- Scoreboard:
  - issue = id_valid & id_issue_long & id_rd_we & ~stall_id & (id_rd != 0). It sets busy_map[id_rd] at the next edge.
  - A long-unit-path write (FIFO pop or bypass) to rd clears busy_map[rd] at the next edge.
  - WB-path writes never clear bits.
  - Set and clear of different registers in the same cycle are both applied. Same-register set+clear cannot occur (WAW stall); if it does, set wins.
- stall_id = id_valid & (busy_map[id_rs1] | busy_map[id_rs2] | (id_rd_we & busy_map[id_rd])).
  - Uses the registered map. busy_map[0] is always 0.
  - A cleared bit releases the stall one cycle after the write, which matches register-file read timing.
- The scheduler has no state machine beyond FIFO pointers, count and bitmap. FIFO order is preserved.

Decomposition:
- Shared package: ADDR_W, DATA_W and NUM_REGS constants, plus a write-request struct {valid, rd, data} used for wb/lu/rf buses.
- One sub-module, rf_wr_fifo (parametric depth, push/pop/count/full/empty). The scoreboard and mux stay in the top.

Test Plan:
- Reset: pulse reset=0 mid-burst with 2 buffered entries -> busy_map=0, count=0, lu_ready=1, no buffered write ever appears on rf_write_reg.
- WB only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF -> same cycle rf_regwrite=1, rf_write_reg=5, rf_write_data=0xDEADBEEF. With wb_rd=0 -> rf_regwrite=0.
- Bypass: wb idle, FIFO empty, lu_valid=1, lu_rd=7, lu_data=0x11 -> rf write of x7=0x11 same cycle, count stays 0, busy_map[7] cleared next cycle.
- Contention: wb_valid=1 for 4 cycles while lu presents x8=0x1, x9=0x2, x10=0x3 -> first two buffered, lu_ready=0 with count=2, x10 held; after WB stops, writes x8, x9, x10 in order on consecutive cycles.
- RAW stall: issue long op rd=3; next ID has rs1=3 -> stall_id=1 until the cycle after the x3 long-unit write, then 0. An unrelated ID (rs1=4, rs2=6, rd=2) -> stall_id=0.
- WAW + x0: ID with id_rd_we=1, rd=3 while busy_map[3]=1 -> stall_id=1. Long issue with rd=0 -> busy_map unchanged.
